// File: rtl/flash_sequencer.sv
// Colour-flash playback sequencer: plays one round of the stored sequence as a
// flash_clk pulse train with a stable check_round index for the display stage.
module flash_sequencer #(
   parameter int unsigned ON_CYCLES  = 25_000_000,
   parameter int unsigned OFF_CYCLES = 12_500_000,
   parameter int unsigned MAX_INDEX  = 32
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       start,
   input  logic       abort,
   input  logic [5:0] last_index,
   output logic       flash_clk,
   output logic [5:0] check_round,
   output logic       busy,
   output logic       done
);

   localparam int unsigned MAX_CYC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
   localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(ON_CYCLES - 1);
   localparam logic [CNT_W-1:0] OFF_LOAD = CNT_W'(OFF_CYCLES - 1);
   localparam logic [5:0]       MAX_IDX  = 6'(MAX_INDEX);

   typedef enum logic [1:0] {IDLE, GAP, ON} state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [5:0]       lim, lim_nxt;
   logic [5:0]       check_round_nxt;
   logic             flash_nxt, busy_nxt, done_nxt;

   // NOTE: state and outputs update with non-blocking assignments only, so every
   // register sees the pre-edge values computed by the combinational block.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         cnt         <= '0;
         lim         <= '0;
         flash_clk   <= 1'b0;
         check_round <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         lim         <= lim_nxt;
         flash_clk   <= flash_nxt;
         check_round <= check_round_nxt;
         busy        <= busy_nxt;
         done        <= done_nxt;
      end
   end

   // NOTE: every output of this block gets a hold/default value first, so no
   // branch leaves a signal unassigned and no latch is inferred.
   always_comb begin
      state_nxt       = state;
      cnt_nxt         = cnt;
      lim_nxt         = lim;
      flash_nxt       = flash_clk;
      check_round_nxt = check_round;
      busy_nxt        = busy;
      done_nxt        = 1'b0;

      // Abort wins over start and over a completion landing on the same edge.
      if (abort) begin
         state_nxt       = IDLE;
         cnt_nxt         = '0;
         flash_nxt       = 1'b0;
         check_round_nxt = '0;
         busy_nxt        = 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  lim_nxt         = (last_index > MAX_IDX) ? MAX_IDX : last_index;
                  check_round_nxt = '0;
                  busy_nxt        = 1'b1;
                  cnt_nxt         = OFF_LOAD;
                  state_nxt       = GAP;
               end
            end
            GAP: begin
               if (cnt == '0) begin
                  flash_nxt = 1'b1;
                  cnt_nxt   = ON_LOAD;
                  state_nxt = ON;
               end else begin
                  cnt_nxt = cnt - 1'b1;
               end
            end
            ON: begin
               if (cnt == '0) begin
                  // The index only advances as flash_clk falls, giving a full gap of settling.
                  flash_nxt = 1'b0;
                  if (check_round < lim) begin
                     check_round_nxt = check_round + 6'd1;
                     cnt_nxt         = OFF_LOAD;
                     state_nxt       = GAP;
                  end else begin
                     busy_nxt  = 1'b0;
                     done_nxt  = 1'b1;
                     state_nxt = IDLE;
                  end
               end else begin
                  cnt_nxt = cnt - 1'b1;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_flash_sequencer.sv
// Scoreboard bench for flash_sequencer: expected flash rises and done edges are
// queued when a playback is started and compared against what the monitor observes.
module tb_flash_sequencer;

   localparam int ON  = 3;
   localparam int OFF = 2;
   localparam int PER = ON + OFF;

   logic       clk = 1'b0;
   logic       reset_n, start, abort;
   logic [5:0] last_index;
   logic       flash_clk, busy, done;
   logic [5:0] check_round;

   typedef struct {
      int         edge_n;
      logic [5:0] idx;
   } flash_t;

   flash_t     exp_q[$], obs_q[$];
   int         exp_done_q[$], obs_done_q[$], obs_fall_q[$];
   int         cyc = 0;
   int         n_checks = 0, n_pass = 0;
   int         cr_viol;
   logic       busy_at_done;
   logic [5:0] cr_at_done;

   flash_sequencer #(.ON_CYCLES(ON), .OFF_CYCLES(OFF), .MAX_INDEX(32)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
      .last_index(last_index), .flash_clk(flash_clk), .check_round(check_round),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic push_expect(input int e0, input int lim);
      for (int k = 0; k <= lim; k++) exp_q.push_back('{e0 + OFF + k * PER, 6'(k)});
      exp_done_q.push_back(e0 + (lim + 1) * PER);
   endtask

   task automatic clear_expect();
      exp_q.delete();
      exp_done_q.delete();
   endtask

   // Caller sits at a negedge; returns at the negedge after the accepting edge.
   task automatic start_pb(input logic [5:0] idx, output int e0);
      start = 1'b1;
      last_index = idx;
      @(negedge clk);
      start = 1'b0;
      e0 = cyc;
      push_expect(e0, (idx > 6'd32) ? 32 : int'(idx));
   endtask

   task automatic collect(input int budget, input bit stop_on_done);
      logic       pf;
      logic [5:0] pc;
      obs_q.delete(); obs_fall_q.delete(); obs_done_q.delete();
      cr_viol = 0; busy_at_done = 1'bx; cr_at_done = 6'bx;
      pf = flash_clk; pc = check_round;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (flash_clk && !pf) obs_q.push_back('{cyc, check_round});
         if (!flash_clk && pf) obs_fall_q.push_back(cyc);
         if (check_round !== pc && flash_clk) cr_viol++;
         if (done) begin
            obs_done_q.push_back(cyc);
            busy_at_done = busy;
            cr_at_done = check_round;
         end
         pf = flash_clk; pc = check_round;
         if (stop_on_done && done) break;
      end
   endtask

   task automatic verify_pb(input string name, input int budget);
      flash_t e, o;
      int n_exp, lim, fall, exp_done, got_done;
      collect(budget, 1'b1);
      n_exp = exp_q.size();
      lim = n_exp - 1;
      n_checks++;
      if (obs_q.size() !== n_exp) $display("FAIL %s pulse_count: got %0d want %0d", name, obs_q.size(), n_exp);
      else n_pass++;
      for (int k = 0; k < n_exp; k++) begin
         e = exp_q.pop_front();
         if (obs_q.size() > 0) o = obs_q.pop_front();
         else o = '{-1, 6'h3f};
         fall = (k < obs_fall_q.size()) ? obs_fall_q[k] : -1;
         n_checks++;
         if (o.edge_n !== e.edge_n) $display("FAIL %s rise_edge[%0d]: got %0d want %0d", name, k, o.edge_n, e.edge_n);
         else n_pass++;
         n_checks++;
         if (o.idx !== e.idx) $display("FAIL %s rise_index[%0d]: got %0d want %0d", name, k, o.idx, e.idx);
         else n_pass++;
         n_checks++;
         if (fall !== e.edge_n + ON) $display("FAIL %s fall_edge[%0d]: got %0d want %0d", name, k, fall, e.edge_n + ON);
         else n_pass++;
      end
      exp_done = exp_done_q.pop_front();
      got_done = (obs_done_q.size() > 0) ? obs_done_q[0] : -1;
      n_checks++;
      if (obs_done_q.size() !== 1) $display("FAIL %s done_count: got %0d want 1", name, obs_done_q.size());
      else n_pass++;
      n_checks++;
      if (got_done !== exp_done) $display("FAIL %s done_edge: got %0d want %0d", name, got_done, exp_done);
      else n_pass++;
      n_checks++;
      if (busy_at_done !== 1'b0) $display("FAIL %s busy_at_done: got %b want 0", name, busy_at_done);
      else n_pass++;
      n_checks++;
      if (cr_at_done !== 6'(lim)) $display("FAIL %s final_index: got %0d want %0d", name, cr_at_done, lim);
      else n_pass++;
      n_checks++;
      if (cr_viol !== 0) $display("FAIL %s index_changed_while_high: got %0d want 0", name, cr_viol);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0) $display("FAIL %s done_width: got %b want 0", name, done);
      else n_pass++;
   endtask

   task automatic check_idle_outputs(input string name);
      n_checks++;
      if ({flash_clk, busy, done, check_round} !== 9'd0)
         $display("FAIL %s idle_outputs: got flash=%b busy=%b done=%b idx=%0d want all 0",
                  name, flash_clk, busy, done, check_round);
      else n_pass++;
   endtask

   task automatic test_reset();
      @(negedge clk);
      check_idle_outputs("reset");
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      check_idle_outputs("post_reset_idle");
   endtask

   task automatic test_single();
      int e0;
      start_pb(6'd0, e0);
      n_checks++;
      if (busy !== 1'b1) $display("FAIL single busy_at_start: got %b want 1", busy);
      else n_pass++;
      verify_pb("single", 20);
   endtask

   task automatic test_multi();
      int e0;
      start_pb(6'd2, e0);
      verify_pb("multi", 40);
   endtask

   task automatic test_clamp();
      int e0;
      start_pb(6'd40, e0);
      verify_pb("clamp", 200);
   endtask

   task automatic test_abort();
      int e0;
      flash_t e;
      start_pb(6'd2, e0);
      collect(7, 1'b0);
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() < 1 || obs_q[0].edge_n !== e.edge_n)
         $display("FAIL abort first_rise: got %0d want %0d", (obs_q.size() > 0) ? obs_q[0].edge_n : -1, e.edge_n);
      else n_pass++;
      clear_expect();
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check_idle_outputs("abort_mid_on");
      collect(2, 1'b0);
      n_checks++;
      if (obs_done_q.size() + obs_q.size() !== 0)
         $display("FAIL abort no_activity: got %0d events want 0", obs_done_q.size() + obs_q.size());
      else n_pass++;
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      n_checks++;
      if (busy !== 1'b0) $display("FAIL abort_over_start busy: got %b want 0", busy);
      else n_pass++;
      start_pb(6'd2, e0);
      verify_pb("abort_restart", 40);
   endtask

   task automatic test_back_to_back();
      int e0;
      start_pb(6'd1, e0);
      fork
         begin
            repeat (2) @(negedge clk);
            start = 1'b1;
            last_index = 6'd5;
            @(negedge clk);
            start = 1'b0;
            repeat (6) @(negedge clk);
            start = 1'b1;
            last_index = 6'd0;
            repeat (2) @(negedge clk);
            start = 1'b0;
            push_expect(e0 + 11, 0);
         end
         verify_pb("b2b_first", 30);
      join
      n_checks++;
      if (busy !== 1'b1) $display("FAIL b2b restart_busy: got %b want 1", busy);
      else n_pass++;
      verify_pb("b2b_second", 20);
   endtask

   task automatic test_async_reset();
      int e0;
      start_pb(6'd2, e0);
      repeat (3) @(negedge clk);
      n_checks++;
      if (flash_clk !== 1'b1) $display("FAIL async_reset pre_flash: got %b want 1", flash_clk);
      else n_pass++;
      #2 reset_n = 1'b0;
      #1 check_idle_outputs("async_reset_immediate");
      clear_expect();
      @(negedge clk);
      reset_n = 1'b1;
      collect(10, 1'b0);
      n_checks++;
      if (obs_q.size() !== 0 || busy !== 1'b0)
         $display("FAIL async_reset stays_idle: got %0d pulses busy=%b want 0 pulses busy=0", obs_q.size(), busy);
      else n_pass++;
   endtask

   initial begin
      reset_n = 1'b0;
      start = 1'b0;
      abort = 1'b0;
      last_index = 6'd0;
      test_reset();
      test_single();
      test_multi();
      test_clamp();
      test_abort();
      test_back_to_back();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/flash_sequencer.md
Name: flash_sequencer

Overview:
- Upstream driver of the colour-flash display stage.
- On a start request, it plays back one round of the stored colour sequence.
- It generates the flash_clk pulse train and the check_round index that the display stage uses to pick segment[check_round] on each rising edge of flash_clk.
- It reports busy/done to the game FSM and supports abort when the game resets mid-playback.

Parameters:
- ON_CYCLES, 25_000_000: clk cycles flash_clk is held high per colour; must be >= 1.
- OFF_CYCLES, 12_500_000: clk cycles flash_clk is held low before each colour, including the lead gap before the first; must be >= 1.
- MAX_INDEX, 32: highest legal sequence index (33-entry sequence).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request playback; sampled only in IDLE.
- abort  in  1  synchronous abort; returns to IDLE.
- last_index  in  6  index of the final colour this round (colours shown = last_index+1); sampled with start.
- flash_clk  out  1  registered flash strobe; rising edge = display samples the colour.
- check_round  out  6  registered index of the colour currently or next shown.
- busy  out  1  high from accepted start until completion or abort.
- done  out  1  single-cycle pulse on normal completion.

Behaviour:
- Reset: while reset_n=0 (asynchronous), state=IDLE, flash_clk=0, check_round=0, busy=0, done=0, counters=0.
- All outputs are registered and change only on posedge clk.
- States: IDLE, GAP, ON.
- IDLE, start=1, abort=0 at edge E0:
  - Latch lim = min(last_index, MAX_INDEX); values >32 clamp to 32.
  - Set check_round<=0, busy<=1, load counter, go to GAP.
- GAP: flash_clk=0 for exactly OFF_CYCLES cycles, then go to ON with flash_clk<=1.
- ON: flash_clk=1 for exactly ON_CYCLES cycles. At the end edge:
  - If check_round<lim: flash_clk<=0, check_round<=check_round+1, go to GAP.
  - If check_round==lim: flash_clk<=0, busy<=0, done<=1, go to IDLE.
- check_round changes only on a falling transition of flash_clk, never on its rising edge. It is stable for >= OFF_CYCLES cycles before each rise.
- Timing:
  - First flash_clk rise at edge E0+OFF_CYCLES.
  - Flash k (0-based) occupies [E0+(k+1)*OFF_CYCLES+k*ON_CYCLES, +ON_CYCLES).
  - Completion edge (done=1, busy=0) = E0+(lim+1)*(OFF_CYCLES+ON_CYCLES).
- done is high exactly one cycle and cleared on the next edge. check_round holds lim after completion until the next start.
- start while busy=1 is ignored; last_index changes while busy are ignored.
- start in the cycle done=1 (state IDLE) is accepted normally.
- abort=1 in any state at an edge: state<=IDLE, flash_clk<=0, busy<=0, done<=0, check_round<=0. abort has priority over start and over normal completion in the same cycle.
- reset_n asserted mid-playback: immediate return to the reset values above, without waiting for clk.
- Counters are sized to hold max(ON_CYCLES, OFF_CYCLES)-1 with no wrap.

Test Plan:
- ON_CYCLES=3, OFF_CYCLES=2, last_index=0, start pulse at E0 -> busy high at E0; flash_clk high at E2..E4 (low from E5); done=1 only in cycle E5..E6; check_round=0 throughout.
- Same params, last_index=2 -> three flash_clk pulses rising at E2, E7, E12; check_round steps 0→1 at E5, 1→2 at E10; done at E15; busy low at E15.
- last_index=40 -> clamped to 32: 33 pulses counted; done at E0+33*5=E165; final check_round=32.
- abort asserted at E8 during playback of last_index=2 -> at E8 flash_clk=0, busy=0, check_round=0, no done pulse; a start at E10 restarts from index 0.
- start re-pulsed at E3 while busy, and start held high through the done cycle -> E3 request ignored; timing unchanged; new playback accepted at the done edge+1 with busy back high.
- reset_n pulled low mid-ON (asynchronously, between edges) -> flash_clk, busy, done and check_round go to 0 immediately; after release, the block stays IDLE until start.
